// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths: FSM encodings,
// parity modes and the baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  // System clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(int unsigned clk, int unsigned baud,
                                           int unsigned os);
    return clk / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV enabled clocks.
// Shared between the rx and tx sides of the UART.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver with 3-sample majority vote and a one-word output register.
// Define UART_PARITY_EN to add a parity bit after the data bits.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 200_000_000,
  parameter int unsigned BAUD_RATE    = 19200,
  parameter int unsigned FRAME_WIDTH  = 8,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [FRAME_WIDTH-1:0] dout,
  output logic                   so,
  input  logic                   ro,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun
);

  localparam int unsigned Div   = baud_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(FRAME_WIDTH);

  localparam logic [TickW-1:0] TickS0   = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE / 2);
  localparam logic [TickW-1:0] TickS2   = TickW'(OVERSAMPLE / 2 + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(FRAME_WIDTH - 1);
  localparam logic             StopLast = 1'(STOP_BITS - 1);

  if (FRAME_WIDTH < 5 || FRAME_WIDTH > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1 || Div < 1) begin : g_param_check
    $error("uart_rx_oversample: illegal parameter set");
  end

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_state_e state_q, state_d;
  logic tick;

  uart_baud_tick #(
    .DIV(Div)
  ) u_baud_tick (
    .sys_clk(sys_clk),
    .reset  (reset),
    .enable (state_q != StIdle),
    .clear  (state_q == StIdle),
    .tick   (tick)
  );

  logic [TickW-1:0]       tick_idx_q, tick_idx_d;
  logic                   s0_q, s1_q;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   ferr_q, ferr_d;
  logic                   wait_high_q, wait_high_d;
  logic                   vote, vote_now, bit_end;
  logic                   commit, commit_ferr, commit_perr;

  assign vote     = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign vote_now = tick && (tick_idx_q == TickS2);
  assign bit_end  = tick && (tick_idx_q == TickLast);

  always_comb begin
    tick_idx_d = tick_idx_q;
    if (state_q == StIdle) begin
      tick_idx_d = '0;
    end else if (tick) begin
      tick_idx_d = (tick_idx_q == TickLast) ? '0 : tick_idx_q + 1'b1;
    end
  end

`ifdef UART_PARITY_EN
  localparam logic ParityMode = (PARITY_ODD != 0) ? ParityOdd : ParityEven;
  logic par_q, par_d;
  assign commit_perr = ((^shift_q) ^ par_q) != ParityMode;
`else
  assign commit_perr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    ferr_d      = ferr_q;
    wait_high_d = wait_high_q;
    commit      = 1'b0;
    commit_ferr = ferr_q;
`ifdef UART_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_sync_q) wait_high_d = 1'b0;
        // After a break the line must return high before a new start is accepted.
        if (!rx_sync_q && !wait_high_q) begin
          state_d = StStart;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (vote_now && vote) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (vote_now) shift_d = {vote, shift_q[FRAME_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BitLast) begin
`ifdef UART_PARITY_EN
            state_d    = StParity;
`else
            state_d    = StStop;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (vote_now) par_d = vote;
        if (bit_end) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      StStop: begin
        if (vote_now) begin
          if (!vote) ferr_d = 1'b1;
          // Commit at mid-bit so a following start edge is never missed.
          if (stop_cnt_q == StopLast) begin
            commit      = 1'b1;
            commit_ferr = ferr_q | ~vote;
            wait_high_d = ferr_q | ~vote;
            state_d     = StIdle;
          end
        end else if (bit_end) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_idx_q  <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      ferr_q      <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_idx_q  <= tick_idx_d;
      if (tick && tick_idx_q == TickS0) s0_q <= rx_sync_q;
      if (tick && tick_idx_q == TickS1) s1_q <= rx_sync_q;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      ferr_q      <= ferr_d;
      wait_high_q <= wait_high_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  logic [FRAME_WIDTH-1:0] dout_q, dout_d;
  logic so_q, so_d, fe_q, fe_d, pe_q, pe_d, overrun_q, overrun_d;

  always_comb begin
    dout_d    = dout_q;
    so_d      = so_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    overrun_d = 1'b0;
    if (commit) begin
      if (!so_q || ro) begin
        dout_d = shift_q;
        fe_d   = commit_ferr;
        pe_d   = commit_perr;
        so_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (so_q && ro) begin
      so_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dout_q    <= '0;
      so_q      <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      so_q      <= so_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign so         = so_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: stimulus pushes expected words, a monitor pops
// and compares on every so && ro transfer. Parity cases run only with UART_PARITY_EN.
module tb_uart_rx_oversample
  import uart_pkg::*;
();

  // 1.2288 MHz / (19200 * 16) gives DIV = 4, so one bit lasts 64 clocks.
  localparam int unsigned ClkHz = 1_228_800;
  localparam int unsigned Bit   = 64;

  logic       sys_clk, reset, rx, ro, so, frame_err, parity_err, overrun;
  logic [7:0] dout;

  uart_rx_oversample #(
    .SYS_CLK_FREQ(ClkHz),
    .BAUD_RATE   (19200),
    .FRAME_WIDTH (8),
    .OVERSAMPLE  (16),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .rx        (rx),
    .dout      (dout),
    .so        (so),
    .ro        (ro),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   overrun_cnt = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (overrun) overrun_cnt++;
      if (so && ro) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, dout}, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dout", {24'd0, dout}, {24'd0, e.d});
          check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (Bit) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input logic use_par, input logic par_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (use_par) drive_bit(par_val);
    drive_bit(stop_val);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic expect_word(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * Bit && exp_q.size() != 0; i++) @(posedge sys_clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  int ov0;

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ro    = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_so", {31'd0, so}, 0);
    check("rst_dout", {24'd0, dout}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_parity_err", {31'd0, parity_err}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    reset = 1'b0;
    drive_bit(1'b1);

    // Plain 8N1 word.
    expect_word(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_a5");

    // Glitch of three ticks must be rejected as a false start.
    rx = 1'b0;
    repeat (12) @(posedge sys_clk);
    #1;
    rx = 1'b1;
    drive_bit(1'b1);
    check("false_start_idle", 32'(dut.state_q), 32'(StIdle));
    expect_word(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_3c");

    // Stop bit low.
    expect_word(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_drain("drain_3c_ferr");

    // Break: exactly one zero word with frame error, no retrigger while low.
    expect_word(8'h00, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (20 * Bit) @(posedge sys_clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    wait_drain("drain_break");

    // Overrun: second word dropped while the first is held.
    ro  = 1'b0;
    ov0 = overrun_cnt;
    expect_word(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    check("overrun_pulses", overrun_cnt - ov0, 1);
    check("held_dout", {24'd0, dout}, 32'h11);
    check("held_so", {31'd0, so}, 1);
    @(posedge sys_clk);
    #1;
    ro = 1'b1;
    @(posedge sys_clk);
    #1;
    check("so_drop_after_xfer", {31'd0, so}, 0);
    wait_drain("drain_11");

    // Reset mid-frame clears a held word and the partial frame.
    ro = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    check("pre_reset_so", {31'd0, so}, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b1;
    #1;
    check("reset_so", {31'd0, so}, 0);
    check("reset_state", 32'(dut.state_q), 32'(StIdle));
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    rx    = 1'b1;
    ro    = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    expect_word(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_81");

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    expect_word(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    expect_word(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_parity");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
